// File: rtl/ktms_mmio_pkg.sv
// Shared MMIO definitions: mmiobus field positions, read data width and the
// read-collector state encoding.
package ktms_mmio_pkg;
  localparam int MMIO_VLD     = 0;
  localparam int MMIO_CFG     = 1;
  localparam int MMIO_RNW     = 2;
  localparam int MMIO_DW      = 3;
  localparam int MMIO_ADDR_LO = 4;
  localparam int MMIO_ADDR_HI = 28;
  localparam int MMIO_DATA_LO = 29;
  localparam int MMIO_DATA_HI = 93;

  localparam int RD_DW = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } rd_state_e;
endpackage

// File: rtl/ktms_mmrd_merge.sv
// Combinational merge of n slave read returns: OR of valid-gated data plus
// any / more-than-one valid detects.
module ktms_mmrd_merge
  import ktms_mmio_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0]       rd_v,
  input  logic [n*RD_DW-1:0] rd_d,
  output logic               any_v,
  output logic               multi_v,
  output logic [RD_DW-1:0]   rd_d_or
);
  logic [n-1:0][RD_DW-1:0] gated;

  for (genvar k = 0; k < n; k++) begin : g_gate
    assign gated[k] = rd_d[k*RD_DW +: RD_DW] & {RD_DW{rd_v[k]}};
  end

  always_comb begin
    rd_d_or = '0;
    for (int k = 0; k < n; k++) rd_d_or |= gated[k];
  end

  assign any_v   = |rd_v;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_v = |(rd_v & (rd_v - n'(1)));
endmodule

// File: rtl/ktms_mmrd_collect.sv
// Collects slave read returns for the single outstanding MMIO read, with a
// default return on timeout and pulsed protocol-error flags.
module ktms_mmrd_collect
  import ktms_mmio_pkg::*;
#(
  parameter int               n             = 4,
  parameter int               mmiobus_width = 94,
  parameter int               timeout       = 255,
  parameter logic [RD_DW-1:0] dflt_data     = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [mmiobus_width-1:0] i_mmiobus,
  input  logic [n-1:0]             i_rd_v,
  input  logic [n*RD_DW-1:0]       i_rd_d,
  output logic                     o_mmio_rd_v,
  output logic [RD_DW-1:0]         o_mmio_rd_d,
  output logic                     o_busy,
  output logic                     o_err_multi,
  output logic                     o_err_timeout,
  output logic                     o_err_unsol,
  output logic                     o_err_ovr
);
  localparam int CW = $clog2(timeout + 1);

  rd_state_e        st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rd_req, any_v, multi_v, expire, in_wait;
  logic [RD_DW-1:0] mrg_d;
  logic             rd_v_d, multi_d, to_d, unsol_d, ovr_d;
  logic [RD_DW-1:0] rd_d_d;
  logic             unused_bus;

  assign rd_req     = i_mmiobus[MMIO_VLD] & i_mmiobus[MMIO_RNW];
  assign unused_bus = ^i_mmiobus;
  assign in_wait    = (st_q == ST_WAIT);
  assign expire     = (cnt_q == CW'(timeout - 1));

  ktms_mmrd_merge #(.n(n)) u_merge (
    .rd_v    (i_rd_v),
    .rd_d    (i_rd_d),
    .any_v   (any_v),
    .multi_v (multi_v),
    .rd_d_or (mrg_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Counter is only nonzero inside WAIT, so it never needs to wrap.
  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    case (st_q)
      ST_IDLE: if (rd_req) st_d = ST_WAIT;
      ST_WAIT: begin
        if (any_v || expire) st_d = ST_IDLE;
        else                 cnt_d = cnt_q + CW'(1);
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // A response in the expiry cycle takes priority over the timeout.
  always_comb begin
    rd_v_d  = in_wait & (any_v | expire);
    rd_d_d  = any_v ? mrg_d : dflt_data;
    multi_d = in_wait & multi_v;
    to_d    = in_wait & ~any_v & expire;
    unsol_d = ~in_wait & any_v;
    ovr_d   = in_wait & rd_req;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_mmio_rd_v   <= 1'b0;
      o_mmio_rd_d   <= '0;
      o_err_multi   <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_unsol   <= 1'b0;
      o_err_ovr     <= 1'b0;
    end else begin
      o_mmio_rd_v   <= rd_v_d;
      if (rd_v_d) o_mmio_rd_d <= rd_d_d;
      o_err_multi   <= multi_d;
      o_err_timeout <= to_d;
      o_err_unsol   <= unsol_d;
      o_err_ovr     <= ovr_d;
    end
  end

  assign o_busy = in_wait;
endmodule

// File: tb/tb_ktms_mmrd_collect.sv
// Self-checking bench for ktms_mmrd_collect: directed scenarios plus random
// traffic against a cycle-age based reference model.
module tb_ktms_mmrd_collect;
  localparam int          N    = 4;
  localparam int          TMO  = 8;
  localparam logic [63:0] DFLT = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [93:0]   mmiobus = '0;
  logic [N-1:0]  rd_v = '0;
  logic [N*64-1:0] rd_d = '0;
  logic          o_mmio_rd_v, o_busy, o_err_multi, o_err_timeout, o_err_unsol, o_err_ovr;
  logic [63:0]   o_mmio_rd_d;

  int nvec = 0;
  int errs = 0;
  int rdv_seen = 0;

  // model state and expectations for the outputs after the next edge
  bit          m_busy = 0;
  int          m_age = 0;
  logic        e_v = 0, e_multi = 0, e_to = 0, e_unsol = 0, e_ovr = 0;
  logic [63:0] e_d = '0;

  ktms_mmrd_collect #(.n(N), .mmiobus_width(94), .timeout(TMO), .dflt_data(DFLT)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .i_mmiobus     (mmiobus),
    .i_rd_v        (rd_v),
    .i_rd_d        (rd_d),
    .o_mmio_rd_v   (o_mmio_rd_v),
    .o_mmio_rd_d   (o_mmio_rd_d),
    .o_busy        (o_busy),
    .o_err_multi   (o_err_multi),
    .o_err_timeout (o_err_timeout),
    .o_err_unsol   (o_err_unsol),
    .o_err_ovr     (o_err_ovr)
  );

  always #5 clk = ~clk;

  task automatic model(input bit req, input logic [N-1:0] v, input logic [N*64-1:0] d);
    logic [63:0] ord;
    ord = '0;
    for (int k = 0; k < N; k++) if (v[k]) ord |= d[k*64 +: 64];
    e_v = 0; e_multi = 0; e_to = 0; e_unsol = 0; e_ovr = 0;
    if (!m_busy) begin
      e_unsol = (v != 0);
      if (req) begin m_busy = 1; m_age = 0; end
    end else begin
      m_age++;
      e_ovr = req;
      if (v != 0) begin
        e_v = 1; e_d = ord; e_multi = ($countones(v) > 1); m_busy = 0;
      end else if (m_age == TMO) begin
        e_v = 1; e_d = DFLT; e_to = 1; m_busy = 0;
      end
    end
  endtask

  task automatic check(input bit chk_data);
    nvec++;
    if (o_mmio_rd_v) rdv_seen++;
    if (o_mmio_rd_v !== e_v) begin errs++; $display("FAIL rd_v got %b exp %b t=%0t", o_mmio_rd_v, e_v, $time); end
    if (o_busy !== m_busy) begin errs++; $display("FAIL busy got %b exp %b t=%0t", o_busy, m_busy, $time); end
    if (o_err_multi !== e_multi) begin errs++; $display("FAIL err_multi got %b exp %b t=%0t", o_err_multi, e_multi, $time); end
    if (o_err_timeout !== e_to) begin errs++; $display("FAIL err_timeout got %b exp %b t=%0t", o_err_timeout, e_to, $time); end
    if (o_err_unsol !== e_unsol) begin errs++; $display("FAIL err_unsol got %b exp %b t=%0t", o_err_unsol, e_unsol, $time); end
    if (o_err_ovr !== e_ovr) begin errs++; $display("FAIL err_ovr got %b exp %b t=%0t", o_err_ovr, e_ovr, $time); end
    if ((chk_data || e_v) && o_mmio_rd_d !== e_d)
      begin errs++; $display("FAIL rd_d got %h exp %h t=%0t", o_mmio_rd_d, e_d, $time); end
  endtask

  task automatic pin(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin errs++; $display("FAIL %s got %h exp %h", name, got, exp); end
  endtask

  // one clock: drive inputs, step the model, compare just after the edge
  task automatic cycle(input bit req, input bit wr, input logic [N-1:0] v, input logic [N*64-1:0] d);
    logic [95:0] junk;
    junk = {$urandom(), $urandom(), $urandom()};
    mmiobus = junk[93:0];
    mmiobus[0] = req | wr;
    mmiobus[2] = req;
    if (!(req | wr) && junk[94]) mmiobus[2] = 1'b1;
    rd_v = v;
    rd_d = d;
    model(req, v, d);
    @(posedge clk);
    #1;
    check(1'b0);
  endtask

  task automatic idle();
    cycle(0, 0, '0, '0);
  endtask

  function automatic logic [N*64-1:0] slv(input int k, input logic [63:0] val);
    logic [N*64-1:0] r;
    r = '0;
    r[k*64 +: 64] = val;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0;
    e_v = 0; e_multi = 0; e_to = 0; e_unsol = 0; e_ovr = 0; e_d = '0;
  endtask

  // async assert away from the edge, check outputs clear at once
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check(1'b1);
    mmiobus = '0; rd_v = '0; rd_d = '0;
    @(posedge clk);
    #1;
    check(1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int base;
    logic [N*64-1:0] d;
    model_reset();
    #3;
    check(1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // single slave return five cycles after the request
    cycle(1, 0, '0, '0);
    repeat (4) idle();
    cycle(0, 0, 4'b0100, slv(2, 64'h0000_0000_DEAD_BEEF));
    pin("t1_rd_v", {63'd0, o_mmio_rd_v}, 64'd1);
    pin("t1_rd_d", o_mmio_rd_d, 64'h0000_0000_DEAD_BEEF);
    pin("t1_busy", {63'd0, o_busy}, 64'd0);
    idle();

    // timeout, then a late response counts as unsolicited
    cycle(1, 0, '0, '0);
    k = 1;
    while (k <= 20) begin
      idle();
      if (o_mmio_rd_v) break;
      k++;
    end
    pin("t2_timeout_latency", 64'(k + 1), 64'd9);
    pin("t2_err_timeout", {63'd0, o_err_timeout}, 64'd1);
    pin("t2_rd_d", o_mmio_rd_d, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    cycle(0, 0, 4'b0001, slv(0, 64'h1234));
    pin("t2_unsol", {63'd0, o_err_unsol}, 64'd1);
    pin("t2_unsol_rd_v", {63'd0, o_mmio_rd_v}, 64'd0);

    // two responders in one cycle
    cycle(1, 0, '0, '0);
    idle();
    cycle(0, 0, 4'b1001, slv(0, 64'h00F0) | slv(3, 64'h0F00));
    pin("t3_rd_d", o_mmio_rd_d, 64'h0FF0);
    pin("t3_multi", {63'd0, o_err_multi}, 64'd1);

    // overlapping request while waiting
    idle();
    base = rdv_seen;
    cycle(1, 0, '0, '0);
    idle();
    cycle(1, 0, '0, '0);
    pin("t4_ovr", {63'd0, o_err_ovr}, 64'd1);
    idle();
    cycle(0, 0, 4'b0010, slv(1, 64'hCAFE_0000_0000_0042));
    pin("t4_rd_d", o_mmio_rd_d, 64'hCAFE_0000_0000_0042);
    repeat (TMO + 3) idle();
    pin("t4_one_return", 64'(rdv_seen - base), 64'd1);

    // response in the expiry cycle wins; write ignored
    cycle(1, 0, '0, '0);
    repeat (TMO - 1) idle();
    cycle(0, 0, 4'b1000, slv(3, 64'h5555_AAAA_0000_0001));
    pin("t5_rd_d", o_mmio_rd_d, 64'h5555_AAAA_0000_0001);
    pin("t5_no_timeout", {63'd0, o_err_timeout}, 64'd0);
    cycle(0, 1, '0, '0);
    pin("t5_write_busy", {63'd0, o_busy}, 64'd0);

    // reset mid-wait abandons the read
    cycle(1, 0, '0, '0);
    repeat (3) idle();
    async_reset();
    cycle(0, 0, 4'b0010, slv(1, 64'h77));
    pin("t6_unsol", {63'd0, o_err_unsol}, 64'd1);
    pin("t6_rd_v", {63'd0, o_mmio_rd_v}, 64'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit req, wr;
      logic [N-1:0] v;
      req = ($urandom_range(0, 5) == 0);
      wr  = !req && ($urandom_range(0, 7) == 0);
      v   = ($urandom_range(0, 6) == 0) ? N'($urandom()) : '0;
      for (int s = 0; s < N; s++) d[s*64 +: 64] = {$urandom(), $urandom()};
      cycle(req, wr, v, d);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
